bp_fe_fetch_scan: RTL and testbench

Registered, multi-instruction scanner for the front end. It accepts one fetch block of `fetch_width_p` bits per handshake and splits it into 16-bit parcels, so that mixed compressed and 32-bit instructions are found. Each instruction found gets a full scan record: branch, jal, jalr, call, ret, compressed, and a sign-extended immediate for both RVC and RV64 forms. A 32-bit instruction that straddles two sequential fetch blocks is stitched together. The block sits between the I-cache response and the branch-target/predict logic, and replaces single-instruction scanning.

---
 rtl/bp_fe_fetch_scan_pkg.sv | 77 +++++++
 rtl/bp_fe_fetch_scan_decode_slot.sv | 71 +++++++
 rtl/bp_fe_fetch_scan.sv | 214 +++++++++++++++++++++
 tb/tb_bp_fe_fetch_scan.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_fetch_scan_pkg.sv
// Shared types and helpers for the front-end fetch scanner.
//   bp_params_e          : processor configuration selector
//   bp_fe_instr_scan_s   : per-instruction scan record (branch/jal/jalr/call/ret/imm)
//   rv64_signext_*_imm   : immediate extraction for B, J, CB and CJ formats
package bp_fe_fetch_scan_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned vaddr_width_gp = 39;

    // Link registers recognised for call/return hints
    localparam logic [4:0] reg_ra_gp = 5'd1;
    localparam logic [4:0] reg_t0_gp = 5'd5;

    localparam logic [6:0] rv64_branch_op_gp = 7'b1100011;
    localparam logic [6:0] rv64_jal_op_gp    = 7'b1101111;
    localparam logic [6:0] rv64_jalr_op_gp   = 7'b1100111;

    typedef struct packed {
        logic                      branch;
        logic                      jal;
        logic                      jalr;
        logic                      call;
        logic                      ret;
        logic [vaddr_width_gp-1:0] imm;
    } bp_fe_instr_scan_s;

    localparam int unsigned instr_scan_width_gp = $bits(bp_fe_instr_scan_s);

    function automatic int unsigned bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

    // B-type: hi = instr[31:25], lo = instr[11:7]
    function automatic logic [vaddr_width_gp-1:0] rv64_signext_b_imm(
        input logic [6:0] hi,
        input logic [4:0] lo
    );
        logic [12:0] imm;
        imm = {hi[6], lo[0], hi[5:0], lo[4:1], 1'b0};
        return {{(vaddr_width_gp-13){imm[12]}}, imm};
    endfunction

    // J-type: f = instr[31:12]
    function automatic logic [vaddr_width_gp-1:0] rv64_signext_j_imm(
        input logic [19:0] f
    );
        logic [20:0] imm;
        imm = {f[19], f[7:0], f[8], f[18:9], 1'b0};
        return {{(vaddr_width_gp-21){imm[20]}}, imm};
    endfunction

    // CB format: hi = instr[12:10], lo = instr[6:2]
    function automatic logic [vaddr_width_gp-1:0] rv64_signext_cb_imm(
        input logic [2:0] hi,
        input logic [4:0] lo
    );
        logic [8:0] imm;
        imm = {hi[2], lo[4:3], lo[0], hi[1:0], lo[2:1], 1'b0};
        return {{(vaddr_width_gp-9){imm[8]}}, imm};
    endfunction

    // CJ format: f = instr[12:2]
    function automatic logic [vaddr_width_gp-1:0] rv64_signext_cj_imm(
        input logic [10:0] f
    );
        logic [11:0] imm;
        imm = {f[10], f[6], f[8:7], f[4], f[5], f[0], f[9], f[3:1], 1'b0};
        return {{(vaddr_width_gp-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/bp_fe_fetch_scan_decode_slot.sv
// Combinational single-slot scanner: classifies one instruction window.
//   instr_i      : 32-bit window; only [15:0] is meaningful when compressed_i
//   compressed_i : window holds an RVC instruction
//   scan_o       : scan record (all-zero for non-control-flow encodings)
module bp_fe_instr_decode_slot
    import bp_fe_fetch_scan_pkg::*;
(
    input  logic [31:0]       instr_i,
    input  logic              compressed_i,
    output bp_fe_instr_scan_s scan_o
);

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [1:0] c_op;
    logic [2:0] c_funct3;
    logic [4:0] c_rs1;
    logic [4:0] c_rs2;
    logic       is_br;
    logic       is_jal;
    logic       is_jalr;

    assign opcode   = instr_i[6:0];
    assign rd       = instr_i[11:7];
    assign rs1      = instr_i[19:15];
    assign c_op     = instr_i[1:0];
    assign c_funct3 = instr_i[15:13];
    assign c_rs1    = instr_i[11:7];
    assign c_rs2    = instr_i[6:2];

    assign is_br   = (opcode == rv64_branch_op_gp);
    assign is_jal  = (opcode == rv64_jal_op_gp);
    assign is_jalr = (opcode == rv64_jalr_op_gp);

    // Record decode; RVC and RV64 paths are mutually exclusive
    always_comb begin
        scan_o = '0;
        if (compressed_i) begin
            if ((c_op == 2'b01) && (c_funct3 == 3'b101)) begin
                scan_o.jal = 1'b1;
                scan_o.imm = rv64_signext_cj_imm(instr_i[12:2]);
            end else if ((c_op == 2'b01) && (c_funct3[2:1] == 2'b11)) begin
                scan_o.branch = 1'b1;
                scan_o.imm    = rv64_signext_cb_imm(instr_i[12:10], instr_i[6:2]);
            end else if ((c_op == 2'b10) && (c_funct3 == 3'b100)
                         && (c_rs2 == 5'd0) && (c_rs1 != 5'd0)) begin
                // rs1 != 0 excludes C.EBREAK
                scan_o.jalr = 1'b1;
                if (instr_i[12]) begin
                    scan_o.call = 1'b1;
                    scan_o.ret  = (c_rs1 == reg_t0_gp);
                end else begin
                    scan_o.ret  = (c_rs1 == reg_ra_gp) || (c_rs1 == reg_t0_gp);
                end
            end
        end else begin
            scan_o.branch = is_br;
            scan_o.jal    = is_jal;
            scan_o.jalr   = is_jalr;
            scan_o.call   = (is_jal || is_jalr) && ((rd == reg_ra_gp) || (rd == reg_t0_gp));
            scan_o.ret    = is_jalr && ((rs1 == reg_ra_gp) || (rs1 == reg_t0_gp)) && (rd != rs1);
            if (is_br) begin
                scan_o.imm = rv64_signext_b_imm(instr_i[31:25], instr_i[11:7]);
            end else if (is_jal) begin
                scan_o.imm = rv64_signext_j_imm(instr_i[31:12]);
            end
        end
    end

endmodule

// File: rtl/bp_fe_fetch_scan.sv
// Multi-instruction fetch-block scanner with cross-block 32-bit stitching.
//   clk_i, reset_i (sync, active-high), redirect_v_i (flush)
//   fetch_v_i / fetch_ready_and_o / fetch_pc_i / fetch_data_i : block input
//   scan_v_o / scan_ready_and_i : registered record handshake
//   scan_base_pc_o, scan_instr_v_o, scan_straddle_o, scan_o,
//   scan_compressed_o, scan_cf_v_o, scan_cf_idx_o : record payload
module bp_fe_fetch_scan
    import bp_fe_fetch_scan_pkg::*;
#(
    parameter  bp_params_e  bp_params_p           = e_bp_default_cfg,
    parameter  int unsigned fetch_width_p         = 64,
    localparam int unsigned vaddr_width_p         = bp_vaddr_width(bp_params_p),
    localparam int unsigned parcels_lp            = fetch_width_p / 16,
    localparam int unsigned fetch_bytes_lp        = fetch_width_p / 8,
    localparam int unsigned instr_scan_width_lp   = instr_scan_width_gp,
    localparam int unsigned parcel_idx_width_lp   = $clog2(parcels_lp),
    localparam int unsigned block_offset_width_lp = $clog2(fetch_bytes_lp)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      redirect_v_i,
    input  logic                                      fetch_v_i,
    output logic                                      fetch_ready_and_o,
    input  logic [vaddr_width_p-1:0]                  fetch_pc_i,
    input  logic [fetch_width_p-1:0]                  fetch_data_i,
    output logic                                      scan_v_o,
    input  logic                                      scan_ready_and_i,
    output logic [vaddr_width_p-1:0]                  scan_base_pc_o,
    output logic [parcels_lp-1:0]                     scan_instr_v_o,
    output logic                                      scan_straddle_o,
    output logic [parcels_lp*instr_scan_width_lp-1:0] scan_o,
    output logic [parcels_lp-1:0]                     scan_compressed_o,
    output logic                                      scan_cf_v_o,
    output logic [parcel_idx_width_lp-1:0]            scan_cf_idx_o
);

    localparam int unsigned scan_vec_width_lp = parcels_lp * instr_scan_width_lp;

    logic [15:0]                    parcel     [parcels_lp];
    logic [31:0]                    win_c      [parcels_lp];
    bp_fe_instr_scan_s              dec_c      [parcels_lp];
    logic [parcels_lp-1:0]          is32_c;
    logic [parcels_lp-1:0]          active_c;
    logic [parcels_lp-1:0]          begin_c;
    logic [parcels_lp-1:0]          compressed_c;
    logic [parcels_lp-1:0]          instr_v_c;
    logic [parcel_idx_width_lp-1:0] start_idx_c;
    logic [parcel_idx_width_lp-1:0] first_idx_c;
    logic                           stitch_c;
    logic                           accept_c;
    logic [scan_vec_width_lp-1:0]   scan_c;
    logic                           cf_v_c;
    logic [parcel_idx_width_lp-1:0] cf_idx_c;
    logic [vaddr_width_p-1:0]       base_pc_c;
    logic [vaddr_width_p-1:0]       last_pc_c;

    logic                           scan_v_q,      scan_v_d;
    logic [vaddr_width_p-1:0]       base_pc_q,     base_pc_d;
    logic [parcels_lp-1:0]          instr_v_q,     instr_v_d;
    logic                           straddle_q,    straddle_d;
    logic [scan_vec_width_lp-1:0]   scan_q,        scan_d;
    logic [parcels_lp-1:0]          compressed_q,  compressed_d;
    logic                           cf_v_q,        cf_v_d;
    logic [parcel_idx_width_lp-1:0] cf_idx_q,      cf_idx_d;
    logic                           resid_v_q,     resid_v_d;
    logic [15:0]                    resid_q,       resid_d;
    logic [vaddr_width_p-1:0]       resid_pc_q,    resid_pc_d;

    assign fetch_ready_and_o = ~reset_i & ~redirect_v_i & (~scan_v_q | scan_ready_and_i);
    assign accept_c          = fetch_v_i & fetch_ready_and_o;

    assign start_idx_c = fetch_pc_i[block_offset_width_lp-1:1];
    assign base_pc_c   = {fetch_pc_i[vaddr_width_p-1:block_offset_width_lp],
                          block_offset_width_lp'(0)};
    assign last_pc_c   = {fetch_pc_i[vaddr_width_p-1:block_offset_width_lp],
                          block_offset_width_lp'(fetch_bytes_lp - 2)};

    // Stitch only when the new block continues exactly where the residual left off
    assign stitch_c = resid_v_q
                    & (start_idx_c == '0)
                    & (fetch_pc_i == (resid_pc_q + vaddr_width_p'(2)));

    // When stitching, parcel 0 is the upper half and the walk resumes at parcel 1
    assign first_idx_c = stitch_c ? parcel_idx_width_lp'(1) : start_idx_c;
    assign active_c    = {parcels_lp{1'b1}} << first_idx_c;

    // Prefix chain: a parcel starts an instruction unless the one below began a 32-bit op
    always_comb begin
        begin_c    = '0;
        begin_c[0] = active_c[0];
        for (int i = 1; i < int'(parcels_lp); i++) begin
            begin_c[i] = active_c[i] & ~(begin_c[i-1] & is32_c[i-1]);
        end
    end

    assign compressed_c = begin_c & ~is32_c;

    // A slot is valid for an RVC op at that parcel or a 32-bit op ending there
    always_comb begin
        instr_v_c    = '0;
        instr_v_c[0] = stitch_c | compressed_c[0];
        for (int i = 1; i < int'(parcels_lp); i++) begin
            instr_v_c[i] = compressed_c[i] | (begin_c[i-1] & is32_c[i-1]);
        end
    end

    for (genvar i = 0; i < int'(parcels_lp); i++) begin : g_slot
        assign parcel[i] = fetch_data_i[16*i +: 16];
        assign is32_c[i] = (parcel[i][1:0] == 2'b11);

        if (i == 0) begin : g_first
            assign win_c[i] = compressed_c[i] ? {16'h0000, parcel[i]} : {parcel[i], resid_q};
        end else begin : g_rest
            assign win_c[i] = compressed_c[i] ? {16'h0000, parcel[i]} : {parcel[i], parcel[i-1]};
        end

        bp_fe_instr_decode_slot u_decode (
            .instr_i      (win_c[i]),
            .compressed_i (compressed_c[i]),
            .scan_o       (dec_c[i])
        );
    end

    // Mask records of invalid slots and find the lowest control-flow slot
    always_comb begin
        scan_c   = '0;
        cf_v_c   = 1'b0;
        cf_idx_c = '0;
        for (int i = 0; i < int'(parcels_lp); i++) begin
            if (instr_v_c[i]) begin
                scan_c[i*instr_scan_width_lp +: instr_scan_width_lp] = dec_c[i];
            end
        end
        for (int i = int'(parcels_lp) - 1; i >= 0; i--) begin
            if (instr_v_c[i] && (dec_c[i].branch || dec_c[i].jal || dec_c[i].jalr)) begin
                cf_v_c   = 1'b1;
                cf_idx_c = parcel_idx_width_lp'(i);
            end
        end
    end

    // Next state: redirect beats accept, accept beats drain
    always_comb begin
        scan_v_d     = scan_v_q;
        base_pc_d    = base_pc_q;
        instr_v_d    = instr_v_q;
        straddle_d   = straddle_q;
        scan_d       = scan_q;
        compressed_d = compressed_q;
        cf_v_d       = cf_v_q;
        cf_idx_d     = cf_idx_q;
        resid_v_d    = resid_v_q;
        resid_d      = resid_q;
        resid_pc_d   = resid_pc_q;

        if (redirect_v_i) begin
            scan_v_d  = 1'b0;
            resid_v_d = 1'b0;
        end else if (accept_c) begin
            scan_v_d     = 1'b1;
            base_pc_d    = base_pc_c;
            instr_v_d    = instr_v_c;
            straddle_d   = stitch_c;
            scan_d       = scan_c;
            compressed_d = compressed_c & instr_v_c;
            cf_v_d       = cf_v_c;
            cf_idx_d     = cf_idx_c;
            resid_v_d    = begin_c[parcels_lp-1] & is32_c[parcels_lp-1];
            resid_d      = parcel[parcels_lp-1];
            resid_pc_d   = last_pc_c;
        end else if (scan_ready_and_i) begin
            scan_v_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scan_v_q     <= 1'b0;
            base_pc_q    <= '0;
            instr_v_q    <= '0;
            straddle_q   <= 1'b0;
            scan_q       <= '0;
            compressed_q <= '0;
            cf_v_q       <= 1'b0;
            cf_idx_q     <= '0;
            resid_v_q    <= 1'b0;
            resid_q      <= '0;
            resid_pc_q   <= '0;
        end else begin
            scan_v_q     <= scan_v_d;
            base_pc_q    <= base_pc_d;
            instr_v_q    <= instr_v_d;
            straddle_q   <= straddle_d;
            scan_q       <= scan_d;
            compressed_q <= compressed_d;
            cf_v_q       <= cf_v_d;
            cf_idx_q     <= cf_idx_d;
            resid_v_q    <= resid_v_d;
            resid_q      <= resid_d;
            resid_pc_q   <= resid_pc_d;
        end
    end

    assign scan_v_o          = scan_v_q;
    assign scan_base_pc_o    = base_pc_q;
    assign scan_instr_v_o    = instr_v_q;
    assign scan_straddle_o   = straddle_q;
    assign scan_o            = scan_q;
    assign scan_compressed_o = compressed_q;
    assign scan_cf_v_o       = cf_v_q;
    assign scan_cf_idx_o     = cf_idx_q;

endmodule

// File: tb/tb_bp_fe_fetch_scan.sv
// Scoreboard bench for bp_fe_fetch_scan (fetch_width_p = 64).
module tb_bp_fe_fetch_scan;
    import bp_fe_fetch_scan_pkg::*;

    localparam int unsigned VW = 39;
    localparam int unsigned PW = 4;
    localparam int unsigned SW = instr_scan_width_gp;
    localparam int unsigned CW = PW * SW;
    localparam bp_fe_instr_scan_s Z = '0;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          redirect_v_i;
    logic          fetch_v_i;
    logic          fetch_ready_and_o;
    logic [VW-1:0] fetch_pc_i;
    logic [63:0]   fetch_data_i;
    logic          scan_v_o;
    logic          scan_ready_and_i;
    logic [VW-1:0] scan_base_pc_o;
    logic [PW-1:0] scan_instr_v_o;
    logic          scan_straddle_o;
    logic [CW-1:0] scan_o;
    logic [PW-1:0] scan_compressed_o;
    logic          scan_cf_v_o;
    logic [1:0]    scan_cf_idx_o;

    bp_fe_fetch_scan #(.fetch_width_p(64)) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .redirect_v_i      (redirect_v_i),
        .fetch_v_i         (fetch_v_i),
        .fetch_ready_and_o (fetch_ready_and_o),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_data_i      (fetch_data_i),
        .scan_v_o          (scan_v_o),
        .scan_ready_and_i  (scan_ready_and_i),
        .scan_base_pc_o    (scan_base_pc_o),
        .scan_instr_v_o    (scan_instr_v_o),
        .scan_straddle_o   (scan_straddle_o),
        .scan_o            (scan_o),
        .scan_compressed_o (scan_compressed_o),
        .scan_cf_v_o       (scan_cf_v_o),
        .scan_cf_idx_o     (scan_cf_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VW-1:0] base_pc;
        logic [PW-1:0] instr_v;
        logic [PW-1:0] comp;
        logic          straddle;
        logic          cf_v;
        logic [1:0]    cf_idx;
        logic [CW-1:0] scan;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   rec_n = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bp_fe_instr_scan_s mk(input logic b, input logic j, input logic jr,
                                             input logic c, input logic r,
                                             input logic [VW-1:0] imm);
        bp_fe_instr_scan_s s;
        s.branch = b;
        s.jal    = j;
        s.jalr   = jr;
        s.call   = c;
        s.ret    = r;
        s.imm    = imm;
        return s;
    endfunction

    function automatic logic [CW-1:0] pack4(input bp_fe_instr_scan_s s0, input bp_fe_instr_scan_s s1,
                                            input bp_fe_instr_scan_s s2, input bp_fe_instr_scan_s s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic push_exp(input logic [VW-1:0] base, input logic [PW-1:0] iv, input logic [PW-1:0] comp,
                            input logic strad, input logic cfv, input logic [1:0] idx,
                            input logic [CW-1:0] sc);
        exp_t e;
        e.base_pc  = base;
        e.instr_v  = iv;
        e.comp     = comp;
        e.straddle = strad;
        e.cf_v     = cfv;
        e.cf_idx   = idx;
        e.scan     = sc;
        exp_q.push_back(e);
    endtask

    // Monitor: every output handshake is compared against the oldest expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (scan_v_o && scan_ready_and_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: got base %0h, expected no record", scan_base_pc_o);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rec%0d.base_pc", rec_n),    256'(scan_base_pc_o),    256'(e.base_pc));
                check($sformatf("rec%0d.instr_v", rec_n),    256'(scan_instr_v_o),    256'(e.instr_v));
                check($sformatf("rec%0d.compressed", rec_n), 256'(scan_compressed_o), 256'(e.comp));
                check($sformatf("rec%0d.straddle", rec_n),   256'(scan_straddle_o),   256'(e.straddle));
                check($sformatf("rec%0d.cf_v", rec_n),       256'(scan_cf_v_o),       256'(e.cf_v));
                if (e.cf_v) begin
                    check($sformatf("rec%0d.cf_idx", rec_n), 256'(scan_cf_idx_o), 256'(e.cf_idx));
                end
                check($sformatf("rec%0d.scan", rec_n),       256'(scan_o),            256'(e.scan));
            end
            rec_n++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Caller must be between a posedge and the following negedge
    task automatic send(input logic [VW-1:0] pc, input logic [63:0] data);
        logic rdy;
        int   n;
        fetch_v_i    = 1'b1;
        fetch_pc_i   = pc;
        fetch_data_i = data;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk_i);
            rdy = fetch_ready_and_o;
            @(posedge clk_i);
            n++;
        end
        #1;
        fetch_v_i = 1'b0;
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept in %0d cycles, expected accept", n);
        end
    endtask

    task automatic expect_next();
        @(negedge clk_i);
        check("latency_v", 256'(scan_v_o), 256'(1));
        step();
    endtask

    localparam logic [VW-1:0] PC0 = 39'h0080000000;
    localparam logic [63:0] D_ALLC   = 64'h0001_0001_0001_0001;
    localparam logic [63:0] D_MIXED  = 64'h8082_A001_0080_006F;
    localparam logic [63:0] D_BRANCH = 64'h9282_FC7D_FE00_0EE3;
    localparam logic [63:0] D_CALL   = 64'h0001_0080_00EF_9002;
    localparam logic [63:0] D_STRA   = 64'h0013_0001_0001_0001;
    localparam logic [63:0] D_STRB   = 64'h0001_0001_0001_0000;
    localparam logic [63:0] D_MIS    = 64'h0001_0001_FFFF_FFFF;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] sc_mixed;
        sc_mixed = pack4(Z, mk(0, 1, 0, 0, 0, 39'd8), mk(0, 1, 0, 0, 0, 39'd0), mk(0, 0, 1, 0, 1, 39'd0));

        reset_i          = 1'b1;
        redirect_v_i     = 1'b0;
        fetch_v_i        = 1'b0;
        fetch_pc_i       = '0;
        fetch_data_i     = '0;
        scan_ready_and_i = 1'b1;
        step();
        step();
        @(negedge clk_i);
        check("reset_ready",    256'(fetch_ready_and_o), 256'(0));
        check("reset_scan_v",   256'(scan_v_o),          256'(0));
        check("reset_instr_v",  256'(scan_instr_v_o),    256'(0));
        check("reset_straddle", 256'(scan_straddle_o),   256'(0));
        step();
        reset_i = 1'b0;

        // All compressed
        push_exp(PC0, 4'b1111, 4'b1111, 0, 0, 2'd0, '0);
        send(PC0, D_ALLC);
        expect_next();

        // Mixed widths with control flow
        push_exp(PC0, 4'b1110, 4'b1100, 0, 1, 2'd1, sc_mixed);
        send(PC0, D_MIXED);
        expect_next();

        // beq -4, c.bnez -2, c.jalr t0
        push_exp(PC0, 4'b1110, 4'b1100, 0, 1, 2'd1,
                 pack4(Z, mk(1, 0, 0, 0, 0, 39'h7F_FFFF_FFFC), mk(1, 0, 0, 0, 0, 39'h7F_FFFF_FFFE),
                       mk(0, 0, 1, 1, 1, 39'd0)));
        send(PC0, D_BRANCH);
        expect_next();

        // c.ebreak, jal ra +8, c.nop
        push_exp(PC0, 4'b1101, 4'b1001, 0, 1, 2'd2,
                 pack4(Z, Z, mk(0, 1, 0, 1, 0, 39'd8), Z));
        send(PC0, D_CALL);
        expect_next();

        // Straddle stitched, back to back
        push_exp(PC0, 4'b0111, 4'b0111, 0, 0, 2'd0, '0);
        send(PC0, D_STRA);
        push_exp(PC0 + 39'd8, 4'b1111, 4'b1110, 1, 0, 2'd0, '0);
        send(PC0 + 39'd8, D_STRB);
        expect_next();

        // Non-sequential follow-up drops the residual
        push_exp(PC0, 4'b0111, 4'b0111, 0, 0, 2'd0, '0);
        send(PC0, D_STRA);
        push_exp(PC0 + 39'h100, 4'b1111, 4'b1111, 0, 0, 2'd0, '0);
        send(PC0 + 39'h100, D_STRB);
        expect_next();

        // Misaligned start
        push_exp(PC0, 4'b1100, 4'b1100, 0, 0, 2'd0, '0);
        send(PC0 + 39'd4, D_MIS);
        expect_next();

        // Backpressure: record holds, input stalls, then zero-bubble refill
        push_exp(PC0, 4'b1110, 4'b1100, 0, 1, 2'd1, sc_mixed);
        send(PC0, D_MIXED);
        scan_ready_and_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check($sformatf("hold%0d_v", k),     256'(scan_v_o),          256'(1));
            check($sformatf("hold%0d_ready", k), 256'(fetch_ready_and_o), 256'(0));
            check($sformatf("hold%0d_iv", k),    256'(scan_instr_v_o),    256'(4'b1110));
            check($sformatf("hold%0d_scan", k),  256'(scan_o),            256'(sc_mixed));
        end
        step();
        scan_ready_and_i = 1'b1;
        push_exp(39'h0080000100, 4'b1100, 4'b1100, 0, 0, 2'd0, '0);
        send(39'h0080000104, D_MIS);
        @(negedge clk_i);
        check("nobubble_v",    256'(scan_v_o),       256'(1));
        check("nobubble_base", 256'(scan_base_pc_o), 256'(39'h0080000100));
        step();

        // Redirect flushes pending record and residual
        scan_ready_and_i = 1'b0;
        send(PC0, D_STRA);
        @(negedge clk_i);
        check("redir_pre_v", 256'(scan_v_o), 256'(1));
        step();
        redirect_v_i = 1'b1;
        @(negedge clk_i);
        check("redir_ready", 256'(fetch_ready_and_o), 256'(0));
        step();
        redirect_v_i = 1'b0;
        @(negedge clk_i);
        check("redir_post_v", 256'(scan_v_o), 256'(0));
        step();
        scan_ready_and_i = 1'b1;
        push_exp(PC0 + 39'd8, 4'b1111, 4'b1111, 0, 0, 2'd0, '0);
        send(PC0 + 39'd8, D_STRB);
        expect_next();

        // Reset mid-operation likewise
        scan_ready_and_i = 1'b0;
        send(PC0, D_STRA);
        @(negedge clk_i);
        check("rst_pre_v", 256'(scan_v_o), 256'(1));
        step();
        reset_i = 1'b1;
        @(negedge clk_i);
        check("rst_ready", 256'(fetch_ready_and_o), 256'(0));
        step();
        reset_i = 1'b0;
        @(negedge clk_i);
        check("rst_post_v",    256'(scan_v_o),       256'(0));
        check("rst_post_iv",   256'(scan_instr_v_o), 256'(0));
        check("rst_post_base", 256'(scan_base_pc_o), 256'(0));
        step();
        scan_ready_and_i = 1'b1;
        push_exp(PC0 + 39'd8, 4'b1111, 4'b1111, 0, 0, 2'd0, '0);
        send(PC0 + 39'd8, D_STRB);
        expect_next();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(negedge clk_i);
        end
        check("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
